mixer_nch: RTL and testbench
============================

Name: mixer_nch

Overview:
Parametrised N-channel audio mixer: out = sat( sum over i of in[i]*gain[i] ), gains in signed Q1.(BITSIZE-2).
Runs on bclk and detects the lrclk frame edge internally.
Uses one time-multiplexed multiplier, one channel per bclk.
Sits between the per-channel sources (oscillators, I2S RX, effects) and the I2S TX; successor to the fixed two-input mixer, adding channel count, a guard-bit accumulator, saturation, a valid strobe and clip/overrun flags.

Parameters:
BITSIZE, 16, sample and gain width; gain 1.0 = 2^(BITSIZE-2).
NCH, 4, number of input channels; legal range 1..60, so a frame (64 bclk) covers the MAC pass.
GUARD, $clog2(NCH)+1, extra accumulator headroom bits.

Ports:
bclk  in  1  sole clock, 64x lrclk.
resetn  in  1  asynchronous, active-low reset.
lrclk  in  1  frame clock; sampled as data on bclk.
in_bus  in  NCH*BITSIZE  signed samples; channel i = bits [i*BITSIZE +: BITSIZE].
gain_bus  in  NCH*BITSIZE  signed Q1.(BITSIZE-2) gains; same packing.
out  out  BITSIZE  signed mixed sample, registered.
out_valid  out  1  one-cycle pulse when out updates.
clip  out  1  one-cycle pulse, coincident with out_valid, when saturation occurred.
frame_err  out  1  one-cycle pulse when a frame edge aborts an unfinished pass.

Behaviour:
- Reset (resetn low, async): out=0, out_valid=0, clip=0, frame_err=0, lrclk_d=0, acc=0, state=IDLE, channel index=0.
- Frame edge: lrclk=1 and lrclk_d=0 at a bclk posedge.
  - lrclk_d resets to 0, so lrclk high at reset release produces an edge on the first clock.
- Cycle numbering: cycle 0 is the edge cycle.
  - Cycle 0: snapshot in_bus and gain_bus into internal registers, acc<=0, idx<=0, state->MAC.
  - Cycles 1..NCH (state MAC): acc <= acc + sext(snap_in[idx]*snap_gain[idx]), idx++.
    - Product is 2*BITSIZE bits, signed.
    - acc is 2*BITSIZE+GUARD bits, so it never overflows.
  - After the last channel: state->OUT.
  - Cycle NCH+1 (state OUT):
    - r = acc >>> (BITSIZE-2); arithmetic shift, i.e. truncation toward -inf, no rounding.
    - out <= clamp(r, -2^(BITSIZE-1), 2^(BITSIZE-1)-1).
    - out_valid<=1; clip<=1 iff clamped.
    - state->IDLE.
- Latency: out and out_valid are visible after the cycle NCH+1 edge, i.e. NCH+1 bclk after the frame edge.
- out holds its value between updates; out_valid and clip are high for exactly one cycle.
- Input changes after cycle 0 do not affect the current pass.
- Frame edge while in MAC or OUT:
  - Abort the current pass: no out update, out_valid=0 that cycle.
  - frame_err pulses in the edge cycle.
  - Restart as cycle 0 with a fresh snapshot.
- Frame edge while in IDLE: normal start, frame_err=0.
- Gain 0x8000 (-2.0 at BITSIZE=16) is legal and multiplies normally.
- NCH=1 degenerates to a single MAC cycle: out at cycle 2.

Decomposition:
- Package mixer_pkg holds:
  - Q-format constants: Q_FRAC = BITSIZE-2, GAIN_ONE.
  - the state enum {IDLE, MAC, OUT}.
  - the accumulator width function.
- Sub-module sat_shift (combinational): acc in, shift by Q_FRAC, clamp. Outputs the BITSIZE result and a clip flag.
- The top level holds the edge detect, snapshot, FSM and accumulator.

Test Plan:
All scenarios use BITSIZE=16, NCH=4.
- Unity pass-through: in0=1000, g0=0x4000, g1..g3=0, lrclk edge -> out=1000 at cycle 5, out_valid one cycle, clip=0.
- Positive saturation: in0=in1=20000, g0=g1=0x4000, others 0 -> out=32767, clip=1 in the same cycle as out_valid.
- Negative saturation and floor rounding:
  - in0=in1=-30000 at unity -> out=-32768, clip=1.
  - separate frame with in0=-3, g0=0x2000 (0.5), others 0 -> out=-2.
- Full sum: in={100,-200,300,-400}, all gains 0x4000 -> out=-200; then change in_bus at cycle 2 -> result still -200.
- Edge mid-pass: second lrclk edge at cycle 2 -> frame_err pulse at cycle 2, no out_valid at original cycle 5; out_valid at cycle 7 with the new snapshot's sum.
- Async reset mid-MAC: drop resetn at cycle 3 -> out=0 and out_valid=0 immediately. After release, the next frame edge produces a correct result.

Source files
------------

// File: rtl/mixer_pkg.sv
// mixer_pkg: Q-format helpers, pass state encoding and accumulator sizing for mixer_nch.
package mixer_pkg;
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   function automatic int q_frac(input int bitsize);
      return bitsize - 2;
   endfunction
   function automatic int gain_one(input int bitsize);
      return 1 << q_frac(bitsize);
   endfunction
   function automatic int acc_width(input int bitsize, input int guard);
      return 2 * bitsize + guard;
   endfunction
endpackage

// File: rtl/sat_shift.sv
// sat_shift: drops the Q fraction bits of the accumulator (floor) and clamps to the sample range.
module sat_shift #(
   parameter int W  = 16,
   parameter int AW = 35,
   parameter int SH = 14
) (
   input  logic signed [AW-1:0] acc,
   output logic signed [W-1:0]  y,
   output logic                 clip
);
   localparam logic signed [AW-1:0] MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
   logic signed [AW-1:0] r;
   assign r    = acc >>> SH;
   assign clip = (r > MAX) || (r < MIN);
   assign y    = r > MAX ? MAX[W-1:0] : r < MIN ? MIN[W-1:0] : r[W-1:0];
endmodule

// File: rtl/mixer_nch.sv
// mixer_nch: N-channel gain mixer, one shared multiplier stepping one channel per bclk after each lrclk rising edge.
module mixer_nch
   import mixer_pkg::*;
#(
   parameter int BITSIZE = 16,
   parameter int NCH     = 4,
   parameter int GUARD   = $clog2(NCH) + 1
) (
   input  logic                      bclk,
   input  logic                      resetn,
   input  logic                      lrclk,
   input  logic [NCH*BITSIZE-1:0]    in_bus,
   input  logic [NCH*BITSIZE-1:0]    gain_bus,
   output logic signed [BITSIZE-1:0] out,
   output logic                      out_valid,
   output logic                      clip,
   output logic                      frame_err
);
   localparam int AW = acc_width(BITSIZE, GUARD);
   localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   state_t                     state;
   logic                       lrclk_d;
   logic [IW-1:0]              idx;
   logic [NCH*BITSIZE-1:0]     snap_in, snap_gain;
   logic signed [AW-1:0]       acc;
   logic signed [BITSIZE-1:0]  cur_in, cur_gain, sat_out;
   logic signed [2*BITSIZE-1:0] prod;
   logic                       sat_clip, frame_edge;

   assign frame_edge = lrclk & ~lrclk_d;
   assign cur_in     = snap_in[idx*BITSIZE +: BITSIZE];
   assign cur_gain   = snap_gain[idx*BITSIZE +: BITSIZE];
   assign prod       = cur_in * cur_gain;

   sat_shift #(.W(BITSIZE), .AW(AW), .SH(q_frac(BITSIZE))) u_sat (
      .acc  (acc),
      .y    (sat_out),
      .clip (sat_clip)
   );

   // A frame edge always wins: it restarts the pass from a fresh snapshot, flagging any pass it cuts short.
   always_ff @(posedge bclk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         lrclk_d   <= 1'b0;
         idx       <= '0;
         acc       <= '0;
         snap_in   <= '0;
         snap_gain <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         clip      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         lrclk_d   <= lrclk;
         out_valid <= 1'b0;
         clip      <= 1'b0;
         frame_err <= 1'b0;
         if (frame_edge) begin
            snap_in   <= in_bus;
            snap_gain <= gain_bus;
            acc       <= '0;
            idx       <= '0;
            state     <= MAC;
            frame_err <= state != IDLE;
         end else if (state == MAC) begin
            acc <= acc + AW'(prod);
            idx <= idx + 1'b1;
            if (idx == LAST) state <= OUT;
         end else if (state == OUT) begin
            out       <= sat_out;
            clip      <= sat_clip;
            out_valid <= 1'b1;
            state     <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_mixer_nch.sv
// tb_mixer_nch: directed and random frames against an arithmetic reference of the mix/saturate rule.
module tb_mixer_nch;
   localparam int BITSIZE = 16;
   localparam int NCH     = 4;

   logic bclk = 1'b0, resetn = 1'b0, lrclk = 1'b0;
   logic [NCH*BITSIZE-1:0] in_bus = '0, gain_bus = '0;
   logic signed [BITSIZE-1:0] out;
   logic out_valid, clip, frame_err;

   int n_chk = 0, n_fail = 0;
   int in_v[NCH], g_v[NCH];

   mixer_nch #(.BITSIZE(BITSIZE), .NCH(NCH)) dut (
      .bclk      (bclk),
      .resetn    (resetn),
      .lrclk     (lrclk),
      .in_bus    (in_bus),
      .gain_bus  (gain_bus),
      .out       (out),
      .out_valid (out_valid),
      .clip      (clip),
      .frame_err (frame_err)
   );

   always #5 bclk = ~bclk;

   function automatic void model(output int o, output bit c);
      longint s = 0, r;
      for (int i = 0; i < NCH; i++) s += longint'(in_v[i]) * longint'(g_v[i]);
      r = s >>> (BITSIZE - 2);
      c = (r > 32767) || (r < -32768);
      o = r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
   endfunction

   task automatic set4(input int a0, a1, a2, a3, b0, b1, b2, b3);
      in_v = '{a0, a1, a2, a3};
      g_v  = '{b0, b1, b2, b3};
   endtask

   task automatic apply();
      for (int i = 0; i < NCH; i++) begin
         in_bus[i*BITSIZE +: BITSIZE]   = in_v[i][BITSIZE-1:0];
         gain_bus[i*BITSIZE +: BITSIZE] = g_v[i][BITSIZE-1:0];
      end
   endtask

   task automatic start_frame(output bit fe);
      @(negedge bclk);
      apply();
      lrclk = 1'b1;
      @(posedge bclk);
      #1 fe = frame_err;
      @(negedge bclk);
      lrclk = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int cyc, output int o, output bit c);
      cyc = -1; o = 0; c = 1'b0;
      for (int n = start + 1; n <= start + 20; n++) begin
         @(posedge bclk);
         #1;
         if (out_valid) begin
            cyc = n; o = int'(out); c = clip;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge bclk);
      #1;
      n_chk++;
      if ({out, out_valid, clip, frame_err} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset: out=%0d valid=%b clip=%b ferr=%b, required all zero", out, out_valid, clip, frame_err);
      end
      @(negedge bclk);
      resetn = 1'b1;
   endtask

   task automatic test_unity();
      bit fe, c; int cyc, o;
      set4(1000, 0, 0, 0, 16384, 0, 0, 0);
      start_frame(fe);
      n_chk++;
      if (fe !== 1'b0) begin n_fail++; $display("FAIL unity_ferr: got %b required 0", fe); end
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (cyc !== 5) begin n_fail++; $display("FAIL unity_latency: got %0d required 5", cyc); end
      n_chk++;
      if (o !== 1000 || c !== 1'b0) begin n_fail++; $display("FAIL unity_out: got %0d clip %b required 1000 clip 0", o, c); end
      @(posedge bclk);
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || clip !== 1'b0 || out !== 16'sd1000) begin
         n_fail++;
         $display("FAIL unity_hold: valid=%b clip=%b out=%0d required 0 0 1000", out_valid, clip, out);
      end
   endtask

   task automatic test_saturation();
      bit fe, c; int cyc, o;
      set4(20000, 20000, 0, 0, 16384, 16384, 0, 0);
      start_frame(fe);
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (o !== 32767 || c !== 1'b1 || cyc !== 5) begin
         n_fail++;
         $display("FAIL pos_sat: got %0d clip %b cyc %0d required 32767 clip 1 cyc 5", o, c, cyc);
      end
      set4(-30000, -30000, 0, 0, 16384, 16384, 0, 0);
      start_frame(fe);
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (o !== -32768 || c !== 1'b1) begin
         n_fail++;
         $display("FAIL neg_sat: got %0d clip %b required -32768 clip 1", o, c);
      end
   endtask

   task automatic test_floor_and_min_gain();
      bit fe, c; int cyc, o;
      set4(-3, 0, 0, 0, 8192, 0, 0, 0);
      start_frame(fe);
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (o !== -2 || c !== 1'b0) begin n_fail++; $display("FAIL floor: got %0d clip %b required -2 clip 0", o, c); end
      set4(1000, 0, 0, 0, -32768, 0, 0, 0);
      start_frame(fe);
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (o !== -2000 || c !== 1'b0) begin n_fail++; $display("FAIL gain_neg2: got %0d clip %b required -2000 clip 0", o, c); end
   endtask

   task automatic test_full_sum_snapshot();
      bit fe, c; int cyc, o;
      set4(100, -200, 300, -400, 16384, 16384, 16384, 16384);
      start_frame(fe);
      @(negedge bclk);
      set4(9000, 9000, 9000, 9000, 16384, 16384, 16384, 16384);
      apply();
      wait_valid(1, cyc, o, c);
      n_chk++;
      if (o !== -200 || c !== 1'b0 || cyc !== 5) begin
         n_fail++;
         $display("FAIL full_sum: got %0d clip %b cyc %0d required -200 clip 0 cyc 5", o, c, cyc);
      end
   endtask

   task automatic test_mid_edge();
      bit fe, c, ec; int cyc, o, eo;
      set4(1, 2, 3, 4, 16384, 16384, 16384, 16384);
      start_frame(fe);
      @(negedge bclk);
      set4(500, 600, -50, 7, 16384, 8192, 16384, -16384);
      model(eo, ec);
      apply();
      lrclk = 1'b1;
      @(posedge bclk);
      #1;
      n_chk++;
      if (frame_err !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_edge_ferr: ferr=%b valid=%b required 1 0", frame_err, out_valid);
      end
      @(negedge bclk);
      lrclk = 1'b0;
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (cyc !== 5 || o !== eo || c !== ec) begin
         n_fail++;
         $display("FAIL mid_edge_out: cyc %0d out %0d clip %b required cyc 5 out %0d clip %b", cyc, o, c, eo, ec);
      end
   endtask

   task automatic test_async_reset();
      bit fe, c; int cyc, o;
      set4(3000, 0, 0, 0, 16384, 0, 0, 0);
      start_frame(fe);
      repeat (3) @(posedge bclk);
      #2 resetn = 1'b0;
      #1;
      n_chk++;
      if (out !== 16'sd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: out=%0d valid=%b required 0 0", out, out_valid);
      end
      @(negedge bclk);
      resetn = 1'b1;
      set4(-1234, 0, 0, 0, 16384, 0, 0, 0);
      start_frame(fe);
      wait_valid(0, cyc, o, c);
      n_chk++;
      if (o !== -1234 || cyc !== 5 || fe !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset: out %0d cyc %0d ferr %b required -1234 5 0", o, cyc, fe);
      end
   endtask

   task automatic test_random();
      bit fe, c, ec; int cyc, o, eo;
      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < NCH; i++) begin
            in_v[i] = int'($urandom_range(0, 65535)) - 32768;
            g_v[i]  = (k % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 16384)) - 8192;
         end
         model(eo, ec);
         start_frame(fe);
         wait_valid(0, cyc, o, c);
         n_chk++;
         if (o !== eo || c !== ec || cyc !== 5 || fe !== 1'b0) begin
            n_fail++;
            $display("FAIL random[%0d]: out %0d clip %b cyc %0d ferr %b required %0d clip %b cyc 5 ferr 0", k, o, c, cyc, fe, eo, ec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_saturation();
      test_floor_and_min_gain();
      test_full_sum_snapshot();
      test_mid_edge();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
